pipe_stage_skid: RTL and testbench

// - Parametrised elastic pipeline stage register with a valid/ready handshake on both sides.
// - Holds one payload in a main register and one in a skid register, so full throughput survives a downstream stall.
// - Adds synchronous flush and back-pressure, which the fixed F/D, D/E, E/M and M/W registers lack.
// - Sits between any two RV32I pipeline stages; the payload is the packed stage bundle (instr, pc, imm, rd, ...).
//

---
 rtl/pipe_stage_skid.sv | 69 ++++++
 tb/tb_pipe_stage_skid.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline stage with a main and a skid register, sync flush.
// Define PIPE_STAGE_PERF_EN to add saturating stall/bubble counters with a sync clear.
module pipe_stage_skid #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);
  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              up, dn;
  assign up      = s_valid & ~skid_valid;
  assign dn      = main_valid & m_ready;
  assign s_ready = ~skid_valid;
  assign m_valid = main_valid;
  assign m_data  = main_data;
  // Skid only fills when main is held by a stall, so it always drains into main first.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= RESET_VAL;
      skid_data  <= RESET_VAL;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (skid_valid) begin
      if (m_ready) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end
    end else if (up & (~main_valid | m_ready)) begin
      main_data  <= s_data;
      main_valid <= 1'b1;
    end else if (up) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
    end else if (dn) begin
      main_valid <= 1'b0;
    end
`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid & ~m_ready & ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (~main_valid & ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed stimulus against a queue model of the stage, plus literal expectations.
module tb_pipe_stage_skid;
  localparam logic [31:0] RV = 32'h0BAD_F00D;
  localparam int CW = 4;
  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0, s_valid = 1'b0, m_ready = 1'b0, cnt_clr = 1'b0;
  logic [31:0] s_data = '0, m_data;
  logic s_ready, m_valid;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  int tests = 0, fails = 0;
  logic [31:0] q[$];
  logic [31:0] got[$];
  int stall_m = 0, bubble_m = 0;

  pipe_stage_skid #(.DATA_W(32), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef PIPE_STAGE_PERF_EN
    , .cnt_clr(cnt_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );
`ifndef PIPE_STAGE_PERF_EN
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

  always #5 clk = ~clk;

  // Model: the stage is a FIFO of capacity two; flush empties it.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q.delete();
      stall_m = 0;
      bubble_m = 0;
    end else begin
      if (cnt_clr) begin
        stall_m = 0;
        bubble_m = 0;
      end else begin
        if (q.size() != 0 && !m_ready && stall_m < 2**CW - 1) stall_m++;
        if (q.size() == 0 && bubble_m < 2**CW - 1) bubble_m++;
      end
      if (flush) q.delete();
      else begin
        automatic bit up = s_valid && q.size() < 2;
        if (q.size() != 0 && m_ready) void'(q.pop_front());
        if (up) q.push_back(s_data);
      end
    end

  always @(posedge clk) if (reset_n && m_valid && m_ready) got.push_back(m_data);

  always @(negedge clk)
    if (reset_n) begin
      tests++;
      if (m_valid !== (q.size() != 0) || s_ready !== (q.size() < 2) ||
          (q.size() != 0 && m_data !== q[0])) begin
        fails++;
        $display("FAIL model t=%0t: m_valid=%b s_ready=%b m_data=%h, required m_valid=%b s_ready=%b m_data=%h",
                 $time, m_valid, s_ready, m_data, q.size() != 0, q.size() < 2,
                 q.size() != 0 ? q[0] : m_data);
      end
`ifdef PIPE_STAGE_PERF_EN
      tests++;
      if (stall_cnt !== CW'(stall_m) || bubble_cnt !== CW'(bubble_m)) begin
        fails++;
        $display("FAIL counters t=%0t: stall=%0d bubble=%0d, required stall=%0d bubble=%0d",
                 $time, stall_cnt, bubble_cnt, stall_m, bubble_m);
      end
`endif
    end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string name, input logic [31:0] exp[$]);
    chk({name, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
    got.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", {31'b0, m_valid}, 32'd0);
    chk("reset_s_ready", {31'b0, s_ready}, 32'd1);
    chk("reset_m_data", m_data, RV);
    reset_n = 1'b1;
    step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
    chk("first_m_valid", {31'b0, m_valid}, 32'd1);
    chk("first_m_data", m_data, 32'hA5A5_0001);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_got("first_out", '{32'hA5A5_0001});
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 1'b1, 1'b0);
      chk("stream_s_ready", {31'b0, s_ready}, 32'd1);
      chk("stream_m_data", m_data, 32'(i));
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk_got("stream_out", '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8});
    step(1'b1, 32'h10, 1'b0, 1'b0);
    chk("one_m_data", m_data, 32'h10);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    chk("two_s_ready", {31'b0, s_ready}, 32'd0);
    step(1'b1, 32'h12, 1'b0, 1'b0);
    chk("two_hold_data", m_data, 32'h10);
    chk("two_hold_ready", {31'b0, s_ready}, 32'd0);
    step(1'b1, 32'h12, 1'b1, 1'b0);
    chk("drain_m_data", m_data, 32'h11);
    step(1'b1, 32'h12, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_got("skid_out", '{32'h10, 32'h11, 32'h12});
    step(1'b1, 32'h20, 1'b0, 1'b0);
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'h99, 1'b0, 1'b1);
    chk("flush_m_valid", {31'b0, m_valid}, 32'd0);
    chk("flush_s_ready", {31'b0, s_ready}, 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, 32'h30, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_got("post_flush_out", '{32'h30});
    step(1'b1, 32'h50, 1'b0, 1'b0);
    step(1'b1, 32'h51, 1'b1, 1'b1);
    chk("flush_dn_m_valid", {31'b0, m_valid}, 32'd0);
    chk_got("flush_dn_out", '{32'h50});
    step(1'b1, 32'h40, 1'b0, 1'b0);
    step(1'b1, 32'h41, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_m_valid", {31'b0, m_valid}, 32'd0);
    chk("async_s_ready", {31'b0, s_ready}, 32'd1);
    chk("async_m_data", m_data, RV);
    @(posedge clk);
    #1 reset_n = 1'b1;
    got.delete();
    step(1'b1, 32'h60, 1'b0, 1'b0);
`ifdef PIPE_STAGE_PERF_EN
    cnt_clr = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    cnt_clr = 1'b0;
    repeat (20) step(1'b0, '0, 1'b0, 1'b0);
    chk("stall_sat", {28'b0, stall_cnt}, 32'd15);
    cnt_clr = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    cnt_clr = 1'b0;
    chk("stall_clr", {28'b0, stall_cnt}, 32'd0);
`endif
    step(1'b0, '0, 1'b1, 1'b0);
    chk_got("tail_out", '{32'h60});
    step(1'b0, '0, 1'b1, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
